// File: rtl/arbitro_fifo_rr4x1_4b.sv
// arbitro_fifo_rr4x1_4b
//   Upstream feeder for a 4x1 valid mux. Four independent lanes each own a
//   small circular FIFO; every cycle one non-empty lane is chosen and its head
//   word is popped onto that lane's data output, with the lane index on
//   selector4x1 and a one-cycle valid_out strobe.
//
//   Build option: define ARB_PRIORIDAD_FIJA_EN for fixed priority (lowest
//   eligible lane index wins). Default is round-robin starting after last_sel.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high
//   push[3:0]           per-lane write strobe
//   data_in0..3         per-lane write data
//   pause               downstream backpressure, blocks the pop this cycle
//   selector4x1         lane index of the last pop
//   valid_out           high for the cycle after a pop
//   data_out0..3        per-lane last popped word, holds otherwise
//   empty/full          per-lane occupancy flags (from registered count)
//   overflow            per-lane sticky flag: a push was dropped on a full lane
module arbitro_fifo_rr4x1_4b #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        push,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              pause,
  output logic [1:0]        selector4x1,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [3:0]        empty,
  output logic [3:0]        full,
  output logic [3:0]        overflow
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [4][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [4];
  logic [PTR_W-1:0]  wr_ptr_d [4];
  logic [PTR_W-1:0]  rd_ptr_q [4];
  logic [PTR_W-1:0]  rd_ptr_d [4];
  logic [PTR_W:0]    count_q [4];
  logic [PTR_W:0]    count_d [4];
  logic [DATA_W-1:0] dout_q [4];
  logic [DATA_W-1:0] dout_d [4];
  logic [DATA_W-1:0] din [4];
  logic [3:0]        overflow_q, overflow_d;
  logic [1:0]        sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [3:0]        eligible, pop, push_acc;
  logic              grant_found, grant_vld;
  logic [1:0]        grant;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  for (genvar n = 0; n < 4; n++) begin : g_flags
    assign empty[n] = (count_q[n] == '0);
    assign full[n]  = (count_q[n] == DEPTH_C);
  end

  // Only words already stored at the start of the cycle can be popped; a push
  // into an empty lane becomes visible next cycle (no fall-through).
  assign eligible = ~empty;

`ifdef ARB_PRIORIDAD_FIJA_EN
  always_comb begin
    grant_found = 1'b0;
    grant       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_found = 1'b1;
        grant       = 2'(i);
      end
    end
  end
`else
  logic [1:0] last_sel_q, last_sel_d;
  logic [1:0] cand;

  // Search starts one past the last granted lane and wraps; the last granted
  // lane itself is tried last.
  always_comb begin
    grant_found = 1'b0;
    grant       = 2'd0;
    cand        = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_sel_q + 2'(i);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
    last_sel_d = last_sel_q;
    if (grant_found && !pause) last_sel_d = grant;
  end

  // Reset value 3 makes lane 0 the first lane searched.
  always_ff @(posedge clk) begin
    if (reset) last_sel_q <= 2'd3;
    else       last_sel_q <= last_sel_d;
  end
`endif

  always_comb begin
    grant_vld  = grant_found && !pause;
    sel_d      = sel_q;
    valid_d    = grant_vld;
    overflow_d = overflow_q;
    if (grant_vld) sel_d = grant;
    for (int n = 0; n < 4; n++) begin
      pop[n]    = grant_vld && (grant == 2'(n));
      dout_d[n] = dout_q[n];
      if (pop[n]) dout_d[n] = mem_q[n][rd_ptr_q[n]];
      // A full lane still accepts a push when it is popped in the same cycle.
      push_acc[n] = push[n] && ((count_q[n] != DEPTH_C) || pop[n]);
      if (push[n] && !push_acc[n]) overflow_d[n] = 1'b1;
      wr_ptr_d[n] = wr_ptr_q[n] + PTR_W'(push_acc[n]);
      rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(pop[n]);
      count_d[n]  = count_q[n] + (PTR_W+1)'(push_acc[n]) - (PTR_W+1)'(pop[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        count_q[n]  <= '0;
        dout_q[n]   <= '0;
      end
      overflow_q <= '0;
      sel_q      <= 2'd0;
      valid_q    <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        count_q[n]  <= count_d[n];
        dout_q[n]   <= dout_d[n];
      end
      overflow_q <= overflow_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
    end
  end

  // Storage needs no reset: pointers and counts decide what is valid.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (push_acc[n]) mem_q[n][wr_ptr_q[n]] <= din[n];
    end
  end

  assign selector4x1 = sel_q;
  assign valid_out   = valid_q;
  assign overflow    = overflow_q;
  assign data_out0   = dout_q[0];
  assign data_out1   = dout_q[1];
  assign data_out2   = dout_q[2];
  assign data_out3   = dout_q[3];

endmodule

// File: tb/tb_arbitro_fifo_rr4x1_4b.sv
// Bench for arbitro_fifo_rr4x1_4b: a behavioural lane/arbiter model predicts
// each pop, pushes it to a scoreboard, and compares when valid_out appears.
module tb_arbitro_fifo_rr4x1_4b;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] push;
  logic [3:0] data_in0, data_in1, data_in2, data_in3;
  logic       pause;
  logic [1:0] selector4x1;
  logic       valid_out;
  logic [3:0] data_out0, data_out1, data_out2, data_out3;
  logic [3:0] empty, full, overflow;

  arbitro_fifo_rr4x1_4b #(.DATA_W(4), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .push(push),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .pause(pause), .selector4x1(selector4x1), .valid_out(valid_out),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [3:0] mq [4][$];
  logic [3:0] mdata [4];
  logic [1:0] msel;
  logic [1:0] mlast;
  logic [3:0] movf;
  logic       mvalid;
  logic [5:0] exp_q [$];   // {selector, word}
  logic [1:0] seq [$];     // observed selectors of valid cycles

`ifdef ARB_PRIORIDAD_FIJA_EN
  localparam logic [1:0] RR_SEQ [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
`else
  localparam logic [1:0] RR_SEQ [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
`endif

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      mq[n].delete();
      mdata[n] = 4'h0;
    end
    msel   = 2'd0;
    mlast  = 2'd3;
    movf   = 4'h0;
    mvalid = 1'b0;
    exp_q.delete();
  endtask

  task automatic compare_outputs();
    logic [3:0] dout [4];
    logic [5:0] e;
    dout = '{data_out0, data_out1, data_out2, data_out3};
    check_eq("valid_out", valid_out, mvalid);
    if (valid_out === 1'b1) begin
      seq.push_back(selector4x1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_selector", selector4x1, e[5:4]);
        check_eq("sb_word", dout[e[5:4]], e[3:0]);
      end
    end
    check_eq("selector_hold", selector4x1, msel);
    for (int n = 0; n < 4; n++) begin
      check_eq($sformatf("data_out%0d", n), dout[n], mdata[n]);
      check_eq($sformatf("empty%0d", n), empty[n], mq[n].size() == 0);
      check_eq($sformatf("full%0d", n), full[n], mq[n].size() == DEPTH);
    end
    check_eq("overflow", overflow, movf);
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, then
  // compare #1 after that edge.
  task automatic step(input logic rst, input logic [3:0] p,
                      input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] d2, input logic [3:0] d3,
                      input logic ps);
    logic [3:0] din [4];
    logic       found;
    logic [1:0] g, c;
    reset = rst; push = p; pause = ps;
    data_in0 = d0; data_in1 = d1; data_in2 = d2; data_in3 = d3;
    din = '{d0, d1, d2, d3};
    if (rst) begin
      model_reset();
    end else begin
      found = 1'b0;
      g = 2'd0;
`ifdef ARB_PRIORIDAD_FIJA_EN
      for (int i = 0; i < 4; i++) begin
        if (!found && mq[i].size() != 0) begin found = 1'b1; g = 2'(i); end
      end
`else
      for (int i = 1; i <= 4; i++) begin
        c = mlast + 2'(i);
        if (!found && mq[c].size() != 0) begin found = 1'b1; g = c; end
      end
`endif
      mvalid = 1'b0;
      if (!ps && found) begin
        mdata[g] = mq[g].pop_front();
        msel = g;
        mlast = g;
        mvalid = 1'b1;
        exp_q.push_back({g, mdata[g]});
      end
      for (int n = 0; n < 4; n++) begin
        if (p[n]) begin
          if (mq[n].size() < DEPTH) mq[n].push_back(din[n]);
          else movf[n] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    push = 4'h0;
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic ps);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, ps);
  endtask

  initial begin
    reset = 1'b0; push = 4'h0; pause = 1'b0;
    data_in0 = 4'h0; data_in1 = 4'h0; data_in2 = 4'h0; data_in3 = 4'h0;
    model_reset();

    // Reset and idle
    step(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    check_eq("rst_empty", empty, 4'hF);
    check_eq("rst_full", full, 4'h0);
    idle(5, 1'b0);

    // Single-lane latency
    step(1'b0, 4'b0100, 4'h0, 4'h0, 4'hA, 4'h0, 1'b0);
    check_eq("lat_no_fallthrough", valid_out, 1'b0);
    idle(1, 1'b0);
    check_eq("lat_valid", valid_out, 1'b1);
    check_eq("lat_sel", selector4x1, 2'd2);
    check_eq("lat_data2", data_out2, 4'hA);
    idle(1, 1'b0);
    check_eq("lat_valid_drop", valid_out, 1'b0);
    check_eq("lat_empty2", empty[2], 1'b1);

    // Round-robin fairness from a fresh reset
    step(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'hF, 4'd0, 4'd2, 4'd4, 4'd6, 1'b1);
    step(1'b0, 4'hF, 4'd1, 4'd3, 4'd5, 4'd7, 1'b1);
    seq.delete();
    idle(8, 1'b0);
    check_eq("rr_count", seq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < seq.size()) check_eq($sformatf("rr_seq%0d", i), seq[i], RR_SEQ[i]);
    end
    idle(1, 1'b0);

    // Full, overflow and simultaneous push/pop on a full lane
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0010, 4'h0, 4'(8 + i), 4'h0, 4'h0, 1'b1);
      if (i == 3) check_eq("full1_at4", full[1], 1'b1);
    end
    check_eq("ovf1", overflow[1], 1'b1);
    step(1'b0, 4'b0010, 4'h0, 4'hD, 4'h0, 4'h0, 1'b0);
    check_eq("full1_pushpop", full[1], 1'b1);
    idle(5, 1'b0);

    // Backpressure with lanes 0 and 3 loaded
    step(1'b0, 4'b1001, 4'h1, 4'h0, 4'h0, 4'h5, 1'b1);
    step(1'b0, 4'b1001, 4'h2, 4'h0, 4'h0, 4'h6, 1'b1);
    idle(1, 1'b1);
    check_eq("bp_hold_valid", valid_out, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    check_eq("bp_pause_valid", valid_out, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b0);

    // Reset mid-operation
    step(1'b0, 4'b0111, 4'h3, 4'h4, 4'h5, 4'h0, 1'b1);
    step(1'b0, 4'b0111, 4'h6, 4'h7, 4'h8, 4'h0, 1'b1);
    idle(1, 1'b0);
    check_eq("mid_valid_before", valid_out, 1'b1);
    step(1'b1, 4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0);
    check_eq("mid_rst_empty", empty, 4'hF);
    check_eq("mid_rst_valid", valid_out, 1'b0);
    check_eq("mid_rst_sel", selector4x1, 2'd0);
    step(1'b0, 4'b1001, 4'h9, 4'h0, 4'h0, 4'hB, 1'b0);
    idle(1, 1'b0);
    check_eq("mid_first_grant", selector4x1, 2'd0);
    check_eq("mid_first_data", data_out0, 4'h9);
    idle(2, 1'b0);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
